// File: rtl/adc_seq_pkg.sv
// Shared state encoding, default widths and period helper for the ADC sample sequencer.
package adc_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SETTLE    = 3'd1;
  localparam state_t ST_CONVERT   = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_GAP       = 3'd4;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_W     = 12;

  // Shortest frame-to-frame spacing that still leaves two GAP cycles.
  function automatic int min_period(input int settle, input int frame, input int slack);
    return settle + frame + slack + 2;
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Frame period counter: restarts on SETTLE entry, latches the clamped period there.
module adc_period_timer
  import adc_seq_pkg::*;
#(
  parameter int PER_W   = 16,
  parameter int MIN_PER = min_period(2, DEF_FRAME_BITS, 4)
) (
  input  logic             SCLK,
  input  logic             reset,
  input  logic             restart,
  input  logic             run,
  input  logic [PER_W-1:0] period,
  output logic [PER_W-1:0] count,
  output logic             tc
);

  localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PER);
  localparam logic [PER_W-1:0] ONE   = PER_W'(1);

  logic [PER_W-1:0] per_lat;

  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      per_lat <= MIN_P;
    end else if (restart) begin
      count   <= '0;
      per_lat <= (period < MIN_P) ? MIN_P : period;
    end else if (run) begin
      count <= count + ONE;
    end
  end

  assign tc = (count == per_lat - ONE);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Drives mux select and CS framing for the serial ADC, tags each received sample with its channel.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int SETTLE_CYC = 2,
  parameter int TO_SLACK   = 4,
  parameter int PER_W      = 16
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              start,
  input  logic              enable,
  input  logic [PER_W-1:0]  period,
  input  logic              err_clr,
  input  logic              rx_done_tick,
  input  logic [DATA_W-1:0] data_in,
  output logic              CS,
  output logic [CH_W-1:0]   chan_sel,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_chan,
  output logic              busy,
  output logic              timeout_err
);

  localparam int MIN_PER = min_period(SETTLE_CYC, FRAME_BITS, TO_SLACK);

  // Phase boundaries are positions of the period counter within a frame.
  localparam logic [PER_W-1:0] SETTLE_END = PER_W'(SETTLE_CYC - 1);
  localparam logic [PER_W-1:0] CONV_END   = PER_W'(SETTLE_CYC + FRAME_BITS - 1);
  localparam logic [PER_W-1:0] WAIT_END   = PER_W'(SETTLE_CYC + FRAME_BITS + TO_SLACK - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  CH_ONE     = CH_W'(1);

  state_t           state;
  logic             cont_mode;
  logic             got_tick;
  logic [PER_W-1:0] pcnt;
  logic             tc;
  logic             launch;
  logic             run_done;
  logic             next_frame;
  logic             capture;

  assign launch     = (state == ST_IDLE) && (enable || start);
  assign run_done   = cont_mode ? !enable : (chan_sel == LAST_CH);
  assign next_frame = (state == ST_GAP) && tc && !run_done;
  assign capture    = rx_done_tick && !got_tick &&
                      ((state == ST_CONVERT) || (state == ST_WAIT_DONE));
  assign busy       = (state != ST_IDLE);

  adc_period_timer #(
    .PER_W   (PER_W),
    .MIN_PER (MIN_PER)
  ) u_timer (
    .SCLK    (SCLK),
    .reset   (reset),
    .restart (launch || next_frame),
    .run     (busy),
    .period  (period),
    .count   (pcnt),
    .tc      (tc)
  );

  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cont_mode    <= 1'b0;
      got_tick     <= 1'b0;
      CS           <= 1'b1;
      chan_sel     <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_chan  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      if (capture) begin
        got_tick     <= 1'b1;
        sample_valid <= 1'b1;
        sample_data  <= data_in;
        sample_chan  <= chan_sel;
      end
      case (state)
        ST_IDLE: begin
          if (launch) begin
            cont_mode <= enable;
            chan_sel  <= '0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          got_tick <= 1'b0;
          if (pcnt == SETTLE_END) begin
            CS    <= 1'b0;
            state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          // A tick already seen in the frame makes the slack wait pointless.
          if (pcnt == CONV_END) begin
            CS    <= 1'b1;
            state <= (got_tick || capture) ? ST_GAP : ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (capture) begin
            state <= ST_GAP;
          end else if (pcnt == WAIT_END) begin
            timeout_err <= 1'b1;
            state       <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tc) begin
            if (run_done) begin
              chan_sel <= '0;
              state    <= ST_IDLE;
            end else begin
              chan_sel <= (chan_sel == LAST_CH) ? '0 : chan_sel + CH_ONE;
              state    <= ST_SETTLE;
            end
          end
        end
        default: begin
          CS    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer with a receiver model and a sample scoreboard.
module tb_adc_sample_sequencer;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int NUM_CH     = 4;
  localparam int CH_W       = 2;
  localparam int SETTLE_CYC = 2;
  localparam int TO_SLACK   = 4;
  localparam int PER_W      = 16;
  localparam int MIN_PER    = SETTLE_CYC + FRAME_BITS + TO_SLACK + 2;
  localparam int SW         = CH_W + DATA_W;

  logic              SCLK;
  logic              reset;
  logic              start;
  logic              enable;
  logic [PER_W-1:0]  period;
  logic              err_clr;
  logic              rx_done_tick;
  logic [DATA_W-1:0] data_in;
  logic              CS;
  logic [CH_W-1:0]   chan_sel;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [CH_W-1:0]   sample_chan;
  logic              busy;
  logic              timeout_err;

  adc_sample_sequencer #(
    .FRAME_BITS (FRAME_BITS), .DATA_W (DATA_W), .NUM_CH (NUM_CH), .CH_W (CH_W),
    .SETTLE_CYC (SETTLE_CYC), .TO_SLACK (TO_SLACK), .PER_W (PER_W)
  ) dut (
    .SCLK (SCLK), .reset (reset), .start (start), .enable (enable), .period (period),
    .err_clr (err_clr), .rx_done_tick (rx_done_tick), .data_in (data_in), .CS (CS),
    .chan_sel (chan_sel), .sample_valid (sample_valid), .sample_data (sample_data),
    .sample_chan (sample_chan), .busy (busy), .timeout_err (timeout_err)
  );

  // clock / reset
  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [SW-1:0]     exp_q[$];
  logic [DATA_W-1:0] rx_data_q[$];

  // receiver model controls, written by the test sequence
  int rx_mode       = 0;   // 0 tick at CS rise, 1 suppress one channel, 2 two ticks inside CONVERT
  int suppress_chan = 2;
  bit stray_arm     = 1'b0;
  int exp_per       = MIN_PER;

  // model state, written by the monitor
  int cyc = 0, low_len = 0, exp_chan = 0, frames_in_run = 0;
  int run_len = 0, last_run_len = 0, last_fall_cyc = 0, to_timer = -1, n_samples = 0;
  bit prev_cs = 1'b1, prev_busy = 1'b0, have_fall = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] next_data();
    if (rx_data_q.size() > 0) return rx_data_q.pop_front();
    return DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
  endfunction

  // receiver model plus frame-timing reference
  always @(negedge SCLK) begin
    logic [DATA_W-1:0] d;
    cyc++;
    rx_done_tick = 1'b0;
    if (!reset) begin
      prev_cs   = 1'b1;
      prev_busy = 1'b0;
      low_len   = 0;
      to_timer  = -1;
    end else begin
      if (busy && !prev_busy) begin
        exp_chan      = 0;
        have_fall     = 1'b0;
        run_len       = 0;
        frames_in_run = 0;
        if (stray_arm) begin
          rx_done_tick = 1'b1;
          data_in      = DATA_W'(12'hBAD);
          stray_arm    = 1'b0;
        end
      end
      if (busy) run_len++;
      if (!busy && prev_busy) last_run_len = run_len;
      if (!CS && prev_cs) begin
        check("chan_at_frame", int'(chan_sel), exp_chan);
        if (have_fall) check("frame_spacing", cyc - last_fall_cyc, exp_per);
        have_fall     = 1'b1;
        last_fall_cyc = cyc;
        frames_in_run++;
        low_len = 0;
      end
      if (!CS) begin
        low_len++;
        if (rx_mode == 2 && low_len == 3) begin
          d = next_data();
          rx_done_tick = 1'b1;
          data_in      = d;
          exp_q.push_back({CH_W'(exp_chan), d});
        end else if (rx_mode == 2 && low_len == 8) begin
          rx_done_tick = 1'b1;
          data_in      = DATA_W'($urandom);
        end
      end
      if (to_timer >= 0) begin
        to_timer++;
        if (to_timer == 3) check("timeout_early", int'(timeout_err), 0);
        if (to_timer == 4) begin
          check("timeout_set", int'(timeout_err), 1);
          to_timer = -1;
        end
      end
      if (CS && !prev_cs) begin
        check("cs_low_len", low_len, FRAME_BITS);
        if (rx_mode == 1 && exp_chan == suppress_chan) begin
          to_timer = 0;
        end else if (rx_mode == 0 || rx_mode == 1) begin
          d = next_data();
          rx_done_tick = 1'b1;
          data_in      = d;
          exp_q.push_back({CH_W'(exp_chan), d});
        end
        exp_chan = (exp_chan + 1) % NUM_CH;
      end
      prev_cs   = CS;
      prev_busy = busy;
    end
  end

  // scoreboard monitor
  always @(negedge SCLK) begin
    logic [SW-1:0] e;
    if (reset && sample_valid) begin
      n_samples++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_sample: got chan %0d data 0x%0h, none expected", sample_chan, sample_data);
      end else begin
        e = exp_q.pop_front();
        check("sample", int'({sample_chan, sample_data}), int'(e));
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge SCLK);
    start = 1'b1;
    @(negedge SCLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge SCLK);
      k++;
    end
    check("idle_reached", int'(busy), 0);
    @(negedge SCLK);
  endtask

  task automatic wait_frames(input int n, input int limit);
    int k = 0;
    while (frames_in_run < n && k < limit) begin
      @(negedge SCLK);
      k++;
    end
    check("frames_reached", int'(frames_in_run >= n), 1);
  endtask

  function automatic int eff(input int p);
    return (p < MIN_PER) ? MIN_PER : p;
  endfunction

  initial begin
    int p, s0, k;
    reset = 1'b1; start = 1'b0; enable = 1'b0; period = '0; err_clr = 1'b0;
    rx_done_tick = 1'b0; data_in = '0;
    #1 reset = 1'b0;
    @(negedge SCLK);
    check("rst_cs", int'(CS), 1);
    check("rst_chan_sel", int'(chan_sel), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_sample_data", int'(sample_data), 0);
    check("rst_sample_chan", int'(sample_chan), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    @(negedge SCLK);
    #2 reset = 1'b1;

    // single sweep, minimum period, fixed data
    rx_data_q = '{12'hA5A, 12'h123, 12'hFFF, 12'h000};
    exp_per = MIN_PER; period = '0; s0 = n_samples;
    pulse_start();
    wait_idle(400);
    check("sweep_len", last_run_len, NUM_CH * MIN_PER);
    check("sweep_samples", n_samples - s0, NUM_CH);
    check("sweep_chan_sel", int'(chan_sel), 0);

    // continuous at period 40, drop enable mid-frame 10
    period = 16'd40; exp_per = 40;
    @(negedge SCLK); enable = 1'b1;
    wait_frames(10, 1000);
    k = 0;
    while (!(low_len >= 5 && !CS) && k < 100) begin @(negedge SCLK); k++; end
    enable = 1'b0;
    wait_idle(200);
    check("cont_len", last_run_len, 10 * 40);
    check("cont_chan_sel", int'(chan_sel), 0);
    check("cont_no_err", int'(timeout_err), 0);

    // suppressed tick on channel 2, then clear
    rx_mode = 1; suppress_chan = 2;
    p = $urandom_range(0, 50); period = PER_W'(p); exp_per = eff(p); s0 = n_samples;
    pulse_start();
    wait_idle(600);
    check("to_sweep_len", last_run_len, NUM_CH * eff(p));
    check("to_samples", n_samples - s0, NUM_CH - 1);
    check("to_sticky", int'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge SCLK);
    err_clr = 1'b0;
    check("err_clr", int'(timeout_err), 0);
    rx_mode = 0;

    // two ticks per window plus a stray tick in SETTLE
    rx_mode = 2; stray_arm = 1'b1;
    rx_data_q.push_back(12'h111);
    p = $urandom_range(0, 50); period = PER_W'(p); exp_per = eff(p); s0 = n_samples;
    pulse_start();
    wait_idle(600);
    check("dbl_samples", n_samples - s0, NUM_CH);
    check("dbl_len", last_run_len, NUM_CH * eff(p));
    rx_mode = 0;

    // asynchronous reset mid-CONVERT
    period = '0; exp_per = MIN_PER;
    pulse_start();
    k = 0;
    while (!(low_len >= 4 && !CS) && k < 100) begin @(negedge SCLK); k++; end
    #2 reset = 1'b0;
    #1;
    check("arst_cs", int'(CS), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_chan_sel", int'(chan_sel), 0);
    @(negedge SCLK);
    @(negedge SCLK);
    #2 reset = 1'b1;
    s0 = n_samples;
    pulse_start();
    wait_idle(400);
    check("post_rst_len", last_run_len, NUM_CH * MIN_PER);
    check("post_rst_samples", n_samples - s0, NUM_CH);

    // start+enable together, start while busy ignored
    p = $urandom_range(20, 45); period = PER_W'(p); exp_per = eff(p);
    @(negedge SCLK); start = 1'b1; enable = 1'b1;
    @(negedge SCLK); start = 1'b0;
    wait_frames(6, 1000);
    pulse_start();
    wait_frames(7, 200);
    enable = 1'b0;
    wait_idle(200);
    check("both_len", last_run_len, 7 * eff(p));
    repeat (10) @(negedge SCLK);
    check("start_busy_ignored", int'(busy), 0);

    // random sweeps
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(0, 60); period = PER_W'(p); exp_per = eff(p); s0 = n_samples;
      pulse_start();
      wait_idle(800);
      check("rnd_len", last_run_len, NUM_CH * eff(p));
      check("rnd_samples", n_samples - s0, NUM_CH);
    end

    repeat (4) @(negedge SCLK);
    check("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
